pdm_frame_buffer: RTL and testbench

Consumer stage for the dual-edge PDM CIC decimator. Generates the decimation strobe that drives the CIC comb section, captures the rise- and fall-edge channel samples as a stereo pair on each decimation period, and buffers the pairs in a small FIFO. Samples leave over a valid/ready stream, one channel word at a time, in rise-then-fall order. The stream feeds the downstream sample processing and transport logic.

---
 rtl/pdm_pkg.sv | 20 ++
 rtl/pdm_pair_fifo.sv | 92 +++++++++
 rtl/pdm_frame_buffer.sv | 190 +++++++++++++++++++
 tb/tb_pdm_frame_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// ---------------------------------------------------------------------------
// pdm_pkg
// Shared definitions for the PDM frame buffer slice: the output FSM state
// encoding and the channel tag values carried on o_chan.
// ---------------------------------------------------------------------------
package pdm_pkg;

  // Output sequencer states: nothing to send, rise word on the bus, fall word
  // on the bus.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_R = 2'd1,
    SEND_F = 2'd2
  } state_e;

  // Channel tag values driven on o_chan.
  localparam logic CHAN_R = 1'b0;
  localparam logic CHAN_F = 1'b1;

endpackage

// File: rtl/pdm_pair_fifo.sv
// ---------------------------------------------------------------------------
// pdm_pair_fifo
// Synchronous FIFO holding stereo pairs. Pointers are one bit wider than the
// address so full and empty are distinguishable. A push on a full FIFO is
// accepted when a pop happens in the same cycle. Pop on empty is ignored.
//
// Ports:
//   i_clk, i_reset     clock, asynchronous active-high reset
//   i_push, i_wdata    write request and entry
//   i_pop              remove the head entry
//   o_head             entry at the read pointer
//   o_head_next        entry one behind the head (valid when o_count > 1)
//   o_full, o_empty    occupancy flags
//   o_count            entries held (registered, reads depth when full)
// ---------------------------------------------------------------------------
module pdm_pair_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [width-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [width-1:0]         o_head,
  output logic [width-1:0]         o_head_next,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(depth):0]   o_count
);

  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s, full_s, empty_s;
  logic [AW-1:0]    rd_addr_next_s;

  assign full_s         = (count_q == PW'(depth));
  assign empty_s        = (count_q == PW'(0));
  assign pop_ok_s       = i_pop && !empty_s;
  // A pop frees the slot the push needs, so full only blocks a lone push.
  assign push_ok_s      = i_push && (!full_s || pop_ok_s);
  assign rd_addr_next_s = rd_ptr_q[AW-1:0] + AW'(1);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = wr_ptr_d - rd_ptr_d;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end
  end

  assign o_head      = mem_q[rd_ptr_q[AW-1:0]];
  assign o_head_next = mem_q[rd_addr_next_s];
  assign o_full      = full_s;
  assign o_empty     = empty_s;
  assign o_count     = count_q;

endmodule

// File: rtl/pdm_frame_buffer.sv
// ---------------------------------------------------------------------------
// pdm_frame_buffer
// Consumer stage for the dual-edge PDM CIC decimator. Produces the comb
// strobe, captures the {rise, fall} channel pair one cycle after each strobe,
// buffers pairs in a FIFO and streams them out one word at a time, rise word
// first, over a valid/ready interface.
//
// Ports:
//   i_clk, i_reset   system clock, asynchronous active-high reset
//   i_dataR/i_dataF  CIC rise/fall channel outputs
//   o_strobe         one-cycle pulse every c_decim cycles (CIC comb enable)
//   o_data, o_chan   output word and its channel tag (0 = rise, 1 = fall)
//   o_valid, i_ready stream handshake
//   o_count          pairs held in the FIFO
//   o_overflow       sticky: a captured pair was dropped
//   i_clear_ovf      synchronous clear of o_overflow (a new drop wins)
// ---------------------------------------------------------------------------
module pdm_frame_buffer
  import pdm_pkg::*;
#(
  parameter int c_width = 8,
  parameter int c_decim = 16,
  parameter int c_depth = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [c_width-1:0]        i_dataR,
  input  logic [c_width-1:0]        i_dataF,
  output logic                      o_strobe,
  output logic [c_width-1:0]        o_data,
  output logic                      o_chan,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [$clog2(c_depth):0]  o_count,
  output logic                      o_overflow,
  input  logic                      i_clear_ovf
);

  localparam int CNT_W  = $clog2(c_decim);
  localparam int PAIR_W = 2 * c_width;
  localparam int CW     = $clog2(c_depth) + 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               strobe_q, strobe_d;
  logic               capture_q, capture_d;
  logic               ovf_q, ovf_d;
  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic [c_width-1:0] data_q, data_d;
  logic               chan_q, chan_d;

  logic [PAIR_W-1:0]  pair_s, head_s, head_next_s;
  logic               full_s, empty_s;
  logic [CW-1:0]      count_s;
  logic               hs_s, pop_s, push_ok_s, drop_s;

  assign pair_s = {i_dataR, i_dataF};
  assign hs_s   = valid_q && i_ready;
  // The head pair leaves when its fall word is accepted.
  assign pop_s  = (state_q == SEND_F) && hs_s;
  assign push_ok_s = capture_q && (!full_s || pop_s);
  assign drop_s    = capture_q && full_s && !pop_s;

  pdm_pair_fifo #(
    .width (PAIR_W),
    .depth (c_depth)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (push_ok_s),
    .i_wdata     (pair_s),
    .i_pop       (pop_s),
    .o_head      (head_s),
    .o_head_next (head_next_s),
    .o_full      (full_s),
    .o_empty     (empty_s),
    .o_count     (count_s)
  );

  // Decimation counter, strobe and capture timing. The strobe is computed
  // from the next count so it is high while the counter sits at c_decim-1;
  // capture follows one cycle later once the CIC comb has updated.
  always_comb begin
    if (cnt_q == CNT_W'(c_decim - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    strobe_d  = (cnt_d == CNT_W'(c_decim - 1));
    capture_d = strobe_q;
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_comb begin
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (i_clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Output sequencer next state and registered stream outputs. On the fall
  // handshake the next rise word comes from the entry behind the head, or,
  // when the head was the only entry, straight from the pair being captured
  // this cycle, so pairs stream back-to-back.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          state_d = SEND_R;
          valid_d = 1'b1;
          data_d  = head_s[PAIR_W-1:c_width];
          chan_d  = CHAN_R;
        end else begin
          valid_d = 1'b0;
        end
      end
      SEND_R: begin
        if (hs_s) begin
          state_d = SEND_F;
          data_d  = head_s[c_width-1:0];
          chan_d  = CHAN_F;
        end else begin
          state_d = SEND_R;
        end
      end
      SEND_F: begin
        if (hs_s) begin
          if (count_s > CW'(1)) begin
            state_d = SEND_R;
            valid_d = 1'b1;
            data_d  = head_next_s[PAIR_W-1:c_width];
            chan_d  = CHAN_R;
          end else if (push_ok_s) begin
            state_d = SEND_R;
            valid_d = 1'b1;
            data_d  = i_dataR;
            chan_d  = CHAN_R;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end else begin
          state_d = SEND_F;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      capture_q <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      data_q    <= '0;
      chan_q    <= CHAN_R;
    end else begin
      cnt_q     <= cnt_d;
      strobe_q  <= strobe_d;
      capture_q <= capture_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      chan_q    <= chan_d;
    end
  end

  assign o_strobe   = strobe_q;
  assign o_data     = data_q;
  assign o_chan     = chan_q;
  assign o_valid    = valid_q;
  assign o_count    = count_s;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pdm_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_pdm_frame_buffer
// Randomized bench for pdm_frame_buffer. A queue of stereo pairs models the
// buffer: pairs join at each capture slot if room exists (a fall-word
// handshake in the same cycle makes room), words must leave in rise-then-fall
// order, and the overflow flag follows the drop/clear rules.
// ---------------------------------------------------------------------------
module tb_pdm_frame_buffer;

  localparam int W     = 8;
  localparam int D     = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  dr, df;
  logic          ready, clr;
  logic          strobe, ochan, ovalid, ovf;
  logic [W-1:0]  odata;
  logic [CW-1:0] ocount;

  always #5 clk = ~clk;

  pdm_frame_buffer #(
    .c_width (W),
    .c_decim (D),
    .c_depth (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_dataR     (dr),
    .i_dataF     (df),
    .o_strobe    (strobe),
    .o_data      (odata),
    .o_chan      (ochan),
    .o_valid     (ovalid),
    .i_ready     (ready),
    .o_count     (ocount),
    .o_overflow  (ovf),
    .i_clear_ovf (clr)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [2*W-1:0] q[$];
  bit             half, ovf_m, b2b_en;
  bit             prev_valid, prev_ready, prev_hs, prev_chan;
  logic [W-1:0]   prev_data;
  int             stall, first_valid, t_cap;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at a falling edge with this cycle's inputs applied: check outputs
  // against the model, advance the model across the next rising edge.
  task automatic tick();
    bit           hs, pop, cap;
    logic [W-1:0] ew;
    hs  = ovalid && ready;
    pop = 1'b0;
    check_eq("strobe", strobe, (cyc % D) == (D - 1));
    check_eq("count", ocount, q.size());
    check_eq("overflow", ovf, ovf_m);
    if (ovalid) check_eq("valid_with_empty", q.size() != 0, 1);
    if (prev_valid && !prev_ready) begin
      check_eq("hold_valid", ovalid, 1);
      check_eq("hold_data", odata, prev_data);
      check_eq("hold_chan", ochan, prev_chan);
    end
    if (b2b_en && prev_hs && q.size() != 0) check_eq("back_to_back", ovalid, 1);
    if (ovalid && first_valid < 0) first_valid = cyc;
    if (q.size() != 0 && !ovalid) stall++;
    else stall = 0;
    if (stall >= 4) begin
      check_eq("valid_late", ovalid, 1);
      stall = 0;
    end
    if (hs && q.size() != 0) begin
      ew = half ? q[0][W-1:0] : q[0][2*W-1:W];
      check_eq("word", odata, ew);
      check_eq("chan", ochan, half);
      pop  = half;
      half = ~half;
    end
    cap = ((cyc % D) == 0) && (cyc != 0);
    if (pop) void'(q.pop_front());
    if (cap && q.size() >= DEPTH) begin
      ovf_m = 1'b1;
    end else begin
      if (cap) q.push_back({dr, df});
      if (clr) ovf_m = 1'b0;
    end
    prev_valid = ovalid;
    prev_ready = ready;
    prev_data  = odata;
    prev_chan  = ochan;
    prev_hs    = hs;
    @(negedge clk);
    cyc++;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases on a
  // falling edge and restarts the model.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_valid", ovalid, 0);
    check_eq("rst_count", ocount, 0);
    check_eq("rst_overflow", ovf, 0);
    check_eq("rst_strobe", strobe, 0);
    check_eq("rst_data", odata, 0);
    check_eq("rst_chan", ochan, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    q.delete();
    half = 1'b0; ovf_m = 1'b0;
    prev_valid = 1'b0; prev_hs = 1'b0; stall = 0;
  endtask

  initial begin
    rst = 1'b1; dr = '0; df = '0; ready = 1'b0; clr = 1'b0;
    half = 1'b0; ovf_m = 1'b0; b2b_en = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_hs = 1'b0; prev_chan = 1'b0;
    prev_data = '0; stall = 0; first_valid = -1;
    @(negedge clk);
    do_reset();

    // Constant pair, consumer always ready: latency and word order.
    dr = 8'h3C; df = 8'hA5; ready = 1'b1;
    while (cyc < 60) tick();
    check_eq("first_valid_cycle", first_valid, D + 2);

    // Consumer stalled: fill with R=n, F=n+1 until the ninth pair drops.
    ready = 1'b0;
    while (cyc <= 12 * D) begin
      dr = 8'(cyc / D - 4);
      df = dr + 8'd1;
      tick();
    end
    check_eq("full_count", ocount, DEPTH);
    check_eq("ovf_after_drop", ovf, 1);

    // Clear the flag, then land the fall handshake on a capture cycle.
    t_cap = ((cyc / D) + 1) * D;
    if (t_cap - cyc < 4) t_cap += D;
    while (cyc <= t_cap) begin
      dr = 8'($urandom); df = 8'($urandom);
      clr   = (cyc == t_cap - 4);
      ready = (cyc >= t_cap - 1);
      tick();
    end
    clr = 1'b0;
    check_eq("pop_push_count", ocount, DEPTH);
    check_eq("pop_push_ovf", ovf, 0);

    // Drain the full FIFO with ready high: words must stream back-to-back.
    ready = 1'b1; b2b_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      dr = 8'($urandom); df = 8'($urandom);
      tick();
    end
    b2b_en = 1'b0;

    // Ready toggling every cycle.
    for (int i = 0; i < 160; i++) begin
      dr = 8'($urandom); df = 8'($urandom);
      ready = (cyc % 2) == 1;
      tick();
    end

    // Random ready (mostly low, then mostly high) with occasional clears.
    for (int i = 0; i < 400; i++) begin
      dr = 8'($urandom); df = 8'($urandom);
      ready = (i < 200) ? ($urandom % 4 == 0) : ($urandom % 5 != 0);
      clr   = ($urandom % 32 == 0);
      tick();
    end
    clr = 1'b0; ready = 1'b1; b2b_en = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || ovalid); i++) begin
      dr = 8'($urandom); df = 8'($urandom);
      tick();
    end
    b2b_en = 1'b0;
    check_eq("drain_count", ocount, 0);

    // Hold three pairs, move to the fall word, then reset mid-transfer.
    ready = 1'b0;
    for (int i = 0; i < 100 && ocount != CW'(3); i++) begin
      dr = 8'($urandom); df = 8'($urandom);
      tick();
    end
    check_eq("wait_count3", ocount, 3);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    check_eq("pre_rst_chan", ochan, 1);
    check_eq("pre_rst_valid", ovalid, 1);
    do_reset();

    // Only freshly captured pairs may appear after reset.
    ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      dr = 8'($urandom); df = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
